// File: rtl/yutorina_bus_if_if.sv
// Shared-bus handshake bundle between the yutorina bus interface unit (master)
// and the external bus arbiter/slave side.
interface yutorina_bus_if_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              bus_req_;
    logic              bus_grnt_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_w_data;
    logic [DATA_W-1:0] bus_r_data;
    logic              bus_rdy_;

    modport master (
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_w_data,
        input  bus_grnt_, bus_r_data, bus_rdy_
    );

    modport slave (
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_w_data,
        output bus_grnt_, bus_r_data, bus_rdy_
    );
endinterface

// File: rtl/yutorina_bus_if.sv
// Memory-access front end for the IF/MEM stages: routes each access to the
// scratch-pad memory or runs the external bus handshake with flush abort and timeout.
//
// state  | meaning
// IDLE   | no bus transaction; SPM accesses are served combinationally
// REQ    | bus_req_ low, waiting for bus_grnt_
// ACCESS | address phase issued, waiting for bus_rdy_
// STALL  | transaction done, holding read data while the pipeline is stalled
module yutorina_bus_if #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int SPM_ADDR_W = 12,
    parameter int SEL_W      = 3,
    parameter int SPM_BASE   = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  as_,
    input  logic                  rw,
    input  logic [DATA_W-1:0]     w_data,
    output logic [DATA_W-1:0]     r_data,
    output logic                  busy,
    output logic                  err,
    output logic [SPM_ADDR_W-1:0] spm_addr,
    output logic                  spm_as_,
    output logic                  spm_rw,
    output logic [DATA_W-1:0]     spm_w_data,
    input  logic [DATA_W-1:0]     spm_r_data,
    yutorina_bus_if_if.master     bus
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [SEL_W-1:0] SPM_SEL = SEL_W'(SPM_BASE);

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

    state_t            state;
    logic [DATA_W-1:0] rd_buf;
    logic [CNT_W-1:0]  cnt;
    logic              drop;
    logic              spm_hit;
    logic              timeout;

    assign spm_hit    = (addr[ADDR_W-1 -: SEL_W] == SPM_SEL);
    assign spm_addr   = addr[SPM_ADDR_W-1:0];
    assign spm_rw     = rw;
    assign spm_w_data = w_data;
    assign spm_as_    = as_ | ~spm_hit | flush;

    // Timeout only fires when the state would otherwise not advance this cycle.
    assign timeout = (TIMEOUT != 0) && (cnt == TO_VAL) &&
                     (((state == REQ) && !flush && bus.bus_grnt_) ||
                      ((state == ACCESS) && bus.bus_rdy_));

    always_comb begin
        busy   = 1'b0;
        err    = 1'b0;
        r_data = '0;
        case (state)
            IDLE: begin
                if (spm_hit)
                    r_data = spm_r_data;
                else if (!as_ && !flush)
                    busy = 1'b1;
            end
            REQ, ACCESS: begin
                if (timeout)
                    err = 1'b1;
                else if ((state == ACCESS) && !bus.bus_rdy_)
                    r_data = bus.bus_r_data;
                else
                    busy = 1'b1;
            end
            STALL: r_data = rd_buf;
            default: ;
        endcase
        if (!rst) begin
            busy = 1'b0;
            err  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            bus.bus_req_   <= 1'b1;
            bus.bus_as_    <= 1'b1;
            bus.bus_addr   <= '0;
            bus.bus_rw     <= 1'b1;
            bus.bus_w_data <= '0;
            rd_buf         <= '0;
            cnt            <= '0;
            drop           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!as_ && !spm_hit && !flush) begin
                        bus.bus_req_ <= 1'b0;
                        cnt          <= '0;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (flush) begin
                        bus.bus_req_ <= 1'b1;
                        state        <= IDLE;
                    end else if (!bus.bus_grnt_) begin
                        bus.bus_addr   <= addr;
                        bus.bus_rw     <= rw;
                        bus.bus_w_data <= w_data;
                        bus.bus_as_    <= 1'b0;
                        state          <= ACCESS;
                    end else if (timeout) begin
                        bus.bus_req_ <= 1'b1;
                        bus.bus_as_  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                ACCESS: begin
                    cnt         <= cnt + 1'b1;
                    bus.bus_as_ <= 1'b1;
                    if (flush)
                        drop <= 1'b1;
                    if (!bus.bus_rdy_) begin
                        rd_buf       <= bus.bus_r_data;
                        bus.bus_req_ <= 1'b1;
                        drop         <= 1'b0;
                        state        <= (stall && !drop && !flush) ? STALL : IDLE;
                    end else if (timeout) begin
                        bus.bus_req_ <= 1'b1;
                        drop         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                STALL: begin
                    if (!stall || flush)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_yutorina_bus_if.sv
// Directed bench for yutorina_bus_if: SPM path, bus handshake, stall hold,
// flush abort, timeout and reset release, with hand-computed expectations.
module tb_yutorina_bus_if;
    logic        clk = 1'b0;
    logic        rst, stall, flush, as_, rw;
    logic [29:0] addr;
    logic [31:0] w_data, r_data, spm_w_data, spm_r_data;
    logic        busy, err, spm_as_, spm_rw;
    logic [11:0] spm_addr;
    int          n_pass = 0;
    int          n_total = 0;

    localparam logic [29:0] BUS_A = 30'h2000_0004;

    yutorina_bus_if_if #(.ADDR_W(30), .DATA_W(32)) bus ();

    yutorina_bus_if #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .addr(addr),
        .as_(as_), .rw(rw), .w_data(w_data), .r_data(r_data), .busy(busy),
        .err(err), .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
        .spm_w_data(spm_w_data), .spm_r_data(spm_r_data), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; as_ = 1; rw = 1; addr = '0; w_data = '0;
        spm_r_data = '0;
        bus.bus_grnt_ = 1; bus.bus_rdy_ = 1; bus.bus_r_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        cyc(); cyc();
        #1;
        n_total++; if (bus.bus_req_ !== 1'b1) $display("FAIL reset_req: got %b want 1", bus.bus_req_); else n_pass++;
        n_total++; if (bus.bus_as_ !== 1'b1) $display("FAIL reset_as: got %b want 1", bus.bus_as_); else n_pass++;
        n_total++; if (bus.bus_rw !== 1'b1) $display("FAIL reset_rw: got %b want 1", bus.bus_rw); else n_pass++;
        n_total++; if (bus.bus_addr !== 30'h0) $display("FAIL reset_addr: got %h want 0", bus.bus_addr); else n_pass++;
        n_total++; if (bus.bus_w_data !== 32'h0) $display("FAIL reset_wdata: got %h want 0", bus.bus_w_data); else n_pass++;
        n_total++; if ({busy, err} !== 2'b00) $display("FAIL reset_busy_err: got %b want 00", {busy, err}); else n_pass++;
        rst = 1;
        cyc();
    endtask

    task automatic test_spm_read();
        idle_inputs();
        addr = 30'h000_0010; as_ = 0; rw = 1; spm_r_data = 32'h1234_5678;
        #1;
        n_total++; if (spm_as_ !== 1'b0) $display("FAIL spm_as: got %b want 0", spm_as_); else n_pass++;
        n_total++; if (spm_addr !== 12'h010) $display("FAIL spm_addr: got %h want 010", spm_addr); else n_pass++;
        n_total++; if (r_data !== 32'h1234_5678) $display("FAIL spm_rdata: got %h want 12345678", r_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL spm_busy: got %b want 0", busy); else n_pass++;
        cyc();
        flush = 1;
        #1;
        n_total++; if (bus.bus_req_ !== 1'b1) $display("FAIL spm_no_bus_req: got %b want 1", bus.bus_req_); else n_pass++;
        n_total++; if (spm_as_ !== 1'b1) $display("FAIL spm_flush_as: got %b want 1", spm_as_); else n_pass++;
        idle_inputs();
        cyc();
    endtask

    // c0 IDLE, c1 REQ (grant), c2 ACCESS (rdy_), optional stall hold afterwards
    task automatic test_bus_read(input bit with_stall);
        idle_inputs();
        addr = BUS_A; as_ = 0; rw = 1;
        bus.bus_grnt_ = 0; bus.bus_rdy_ = 0; bus.bus_r_data = 32'hDEAD_BEEF;
        #1;
        n_total++; if (busy !== 1'b1) $display("FAIL rd_c0_busy: got %b want 1", busy); else n_pass++;
        cyc(); #1;
        n_total++; if ({busy, bus.bus_req_, bus.bus_as_} !== 3'b101) $display("FAIL rd_c1_busy_req_as: got %b want 101", {busy, bus.bus_req_, bus.bus_as_}); else n_pass++;
        if (with_stall) stall = 1;
        cyc(); #1;
        n_total++; if ({busy, bus.bus_req_, bus.bus_as_} !== 3'b000) $display("FAIL rd_c2_busy_req_as: got %b want 000", {busy, bus.bus_req_, bus.bus_as_}); else n_pass++;
        n_total++; if (r_data !== 32'hDEAD_BEEF) $display("FAIL rd_c2_rdata: got %h want deadbeef", r_data); else n_pass++;
        n_total++; if (bus.bus_addr !== BUS_A) $display("FAIL rd_c2_bus_addr: got %h want %h", bus.bus_addr, BUS_A); else n_pass++;
        cyc();
        as_ = 1; bus.bus_r_data = 32'h0; bus.bus_grnt_ = 1; bus.bus_rdy_ = 1;
        #1;
        n_total++; if ({busy, bus.bus_req_, bus.bus_as_} !== 3'b011) $display("FAIL rd_c3_busy_req_as: got %b want 011", {busy, bus.bus_req_, bus.bus_as_}); else n_pass++;
        if (with_stall) begin
            for (int i = 0; i < 2; i++) begin
                n_total++; if (r_data !== 32'hDEAD_BEEF) $display("FAIL stall_hold_rdata%0d: got %h want deadbeef", i, r_data); else n_pass++;
                cyc(); #1;
            end
            stall = 0;
            #1;
            n_total++; if (r_data !== 32'hDEAD_BEEF) $display("FAIL stall_last_rdata: got %h want deadbeef", r_data); else n_pass++;
            cyc(); #1;
            n_total++; if (r_data !== 32'h0) $display("FAIL stall_exit_idle_rdata: got %h want 0", r_data); else n_pass++;
        end else begin
            n_total++; if (r_data !== 32'h0) $display("FAIL rd_c3_idle_rdata: got %h want 0", r_data); else n_pass++;
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_flush_req();
        idle_inputs();
        addr = BUS_A; as_ = 0;
        cyc();
        flush = 1; bus.bus_grnt_ = 0;
        #1;
        n_total++; if (busy !== 1'b1) $display("FAIL flush_req_busy: got %b want 1", busy); else n_pass++;
        cyc();
        flush = 0; as_ = 1;
        #1;
        n_total++; if ({bus.bus_req_, bus.bus_as_, busy} !== 3'b110) $display("FAIL flush_next_req_as_busy: got %b want 110", {bus.bus_req_, bus.bus_as_, busy}); else n_pass++;
        cyc(); #1;
        n_total++; if (bus.bus_as_ !== 1'b1) $display("FAIL flush_as_stays_high: got %b want 1", bus.bus_as_); else n_pass++;
        idle_inputs();
        cyc();
    endtask

    task automatic test_timeout();
        idle_inputs();
        addr = BUS_A; as_ = 0; bus.bus_grnt_ = 1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if ({busy, err} !== 2'b10) $display("FAIL to_req%0d_busy_err: got %b want 10", i, {busy, err}); else n_pass++;
            cyc();
        end
        #1;
        n_total++; if ({busy, err} !== 2'b01) $display("FAIL to_fire_busy_err: got %b want 01", {busy, err}); else n_pass++;
        n_total++; if (r_data !== 32'h0) $display("FAIL to_fire_rdata: got %h want 0", r_data); else n_pass++;
        cyc();
        as_ = 1;
        #1;
        n_total++; if ({bus.bus_req_, err, busy} !== 3'b100) $display("FAIL to_after_req_err_busy: got %b want 100", {bus.bus_req_, err, busy}); else n_pass++;
        idle_inputs();
        cyc();
    endtask

    // grant in first REQ cycle, rdy_ arrives exactly when cnt == TIMEOUT
    task automatic test_rdy_timeout_tie();
        idle_inputs();
        addr = BUS_A; as_ = 0; bus.bus_grnt_ = 0; bus.bus_rdy_ = 1;
        bus.bus_r_data = 32'hCAFE_0001;
        cyc(); cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if ({busy, err} !== 2'b10) $display("FAIL tie_wait%0d_busy_err: got %b want 10", i, {busy, err}); else n_pass++;
            cyc();
        end
        bus.bus_rdy_ = 0;
        #1;
        n_total++; if ({busy, err} !== 2'b00) $display("FAIL tie_busy_err: got %b want 00", {busy, err}); else n_pass++;
        n_total++; if (r_data !== 32'hCAFE_0001) $display("FAIL tie_rdata: got %h want cafe0001", r_data); else n_pass++;
        cyc();
        idle_inputs();
        cyc();
    endtask

    // write with one grant-wait cycle; stall and flush together at completion
    task automatic test_write_stall_flush();
        idle_inputs();
        addr = BUS_A; as_ = 0; rw = 0; w_data = 32'hA5A5_0F0F;
        bus.bus_grnt_ = 1; bus.bus_rdy_ = 0; bus.bus_r_data = 32'h5555_AAAA;
        cyc(); cyc();
        bus.bus_grnt_ = 0;
        #1;
        n_total++; if (busy !== 1'b1) $display("FAIL wr_grant_wait_busy: got %b want 1", busy); else n_pass++;
        cyc();
        stall = 1; flush = 1;
        #1;
        n_total++; if ({bus.bus_as_, bus.bus_rw, busy} !== 3'b000) $display("FAIL wr_access_as_rw_busy: got %b want 000", {bus.bus_as_, bus.bus_rw, busy}); else n_pass++;
        n_total++; if (bus.bus_w_data !== 32'hA5A5_0F0F) $display("FAIL wr_bus_wdata: got %h want a5a50f0f", bus.bus_w_data); else n_pass++;
        cyc();
        flush = 0; as_ = 1;
        #1;
        n_total++; if (r_data !== 32'h0) $display("FAIL stall_flush_goes_idle: got %h want 0", r_data); else n_pass++;
        idle_inputs();
        cyc();
    endtask

    task automatic test_reset_access();
        idle_inputs();
        addr = BUS_A; as_ = 0; rw = 0; w_data = 32'h0BAD_F00D;
        bus.bus_grnt_ = 0; bus.bus_rdy_ = 1;
        cyc(); cyc();
        rst = 0;
        #1;
        n_total++; if ({busy, err, bus.bus_rw, bus.bus_as_} !== 4'b0000) $display("FAIL rst_in_access_busy_err_rw_as: got %b want 0000", {busy, err, bus.bus_rw, bus.bus_as_}); else n_pass++;
        cyc(); #1;
        n_total++; if ({bus.bus_req_, bus.bus_as_, bus.bus_rw, busy} !== 4'b1110) $display("FAIL rst_release_req_as_rw_busy: got %b want 1110", {bus.bus_req_, bus.bus_as_, bus.bus_rw, busy}); else n_pass++;
        n_total++; if (bus.bus_addr !== 30'h0) $display("FAIL rst_release_addr: got %h want 0", bus.bus_addr); else n_pass++;
        n_total++; if (bus.bus_w_data !== 32'h0) $display("FAIL rst_release_wdata: got %h want 0", bus.bus_w_data); else n_pass++;
        rst = 1;
        idle_inputs();
        cyc();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        @(negedge clk);
        test_reset();
        test_spm_read();
        test_bus_read(1'b0);
        test_bus_read(1'b1);
        test_flush_req();
        test_timeout();
        test_rdy_timeout_tie();
        test_write_stall_flush();
        test_reset_access();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
